// File: rtl/mouse_packet_receiver.sv
// PS/2 mouse receiver: synchronises the pins, decodes 11-bit frames and
// assembles 3-byte packets into one word with a single-cycle write strobe.
module mouse_packet_receiver #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [31:0] MouseData,
    output logic        MouseEnable,
    output logic        FrameError,
    output logic [1:0]  ByteCount
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q;
    logic          pc_s1_q, pc_s2_q, pc_prev_q;
    logic          pd_s1_q, pd_s2_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic [1:0]    bcnt_q;
    logic [7:0]    byte0_q, byte1_q;
    logic [31:0]   data_q;
    logic          me_q, fe_q;

    logic fall_d, dbit_d, timeout_d, good_d;

    always_comb begin
        fall_d    = pc_prev_q & ~pc_s2_q;
        dbit_d    = pd_s2_q;
        timeout_d = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);
        good_d    = dbit_d && (^{par_q, shreg_q});
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            pc_s1_q   <= 1'b1;
            pc_s2_q   <= 1'b1;
            pc_prev_q <= 1'b1;
            pd_s1_q   <= 1'b1;
            pd_s2_q   <= 1'b1;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            bcnt_q    <= '0;
            byte0_q   <= '0;
            byte1_q   <= '0;
            data_q    <= '0;
            me_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            pc_s1_q   <= PS2_CLK;
            pc_s2_q   <= pc_s1_q;
            pc_prev_q <= pc_s2_q;
            pd_s1_q   <= PS2_DATA;
            pd_s2_q   <= pd_s1_q;
            me_q      <= 1'b0;
            fe_q      <= 1'b0;

            if (fall_d || state_q == S_IDLE) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            // A falling edge takes priority over an expiring timeout
            if (fall_d) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (!dbit_d) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end else begin
                            fe_q   <= 1'b1;
                            bcnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg_q <= {dbit_d, shreg_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_q   <= dbit_d;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (good_d) begin
                            unique case (bcnt_q)
                                2'd0: begin
                                    // bit3 is always set in a status byte
                                    if (shreg_q[3]) begin
                                        byte0_q <= shreg_q;
                                        bcnt_q  <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    byte1_q <= shreg_q;
                                    bcnt_q  <= 2'd2;
                                end
                                default: begin
                                    data_q <= {8'h00, byte0_q, byte1_q, shreg_q};
                                    me_q   <= 1'b1;
                                    bcnt_q <= '0;
                                end
                            endcase
                        end else begin
                            fe_q   <= 1'b1;
                            bcnt_q <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (timeout_d) begin
                state_q <= S_IDLE;
                bcnt_q  <= '0;
                fe_q    <= 1'b1;
            end
        end
    end

    assign MouseData   = data_q;
    assign MouseEnable = me_q;
    assign FrameError  = fe_q;
    assign ByteCount   = bcnt_q;

endmodule
